// File: rtl/mem_rmw_ctrl.sv
// Sub-word store controller: loads and aligned word stores pass straight through,
// while SB/SH become a stalled two-cycle read-modify-write of the containing word.
module mem_rmw_ctrl #(
    parameter int unsigned DM_ADDRESS = 9,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [2:0]            Funct3,
    output logic                  dm_MemRead,
    output logic                  dm_MemWrite,
    output logic [DM_ADDRESS-1:0] dm_a,
    output logic [DATA_W-1:0]     dm_wd,
    output logic [2:0]            dm_Funct3,
    input  logic [DATA_W-1:0]     dm_rd,
    output logic                  stall,
    output logic                  misalign_err,
    output logic [CNT_W-1:0]      rmw_count
);

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Captured sub-word store; only the low halfword of data is ever merged.
    typedef struct packed {
        logic [DM_ADDRESS-1:0] addr;
        logic [15:0]           wdata;
        logic [1:0]            size;
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [DATA_W-1:0] old_q, old_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic              is_load;
    logic              is_store;
    logic              sub_word;
    logic              misaligned;
    logic [DATA_W-1:0] merged;

    // Request decode; a load wins over a simultaneous store.
    always_comb begin
        is_load    = MemRead;
        is_store   = MemWrite & ~MemRead;
        sub_word   = 1'b0;
        misaligned = 1'b0;
        if (is_store) begin
            case (Funct3[1:0])
                SZ_BYTE: sub_word = 1'b1;
                SZ_HALF: begin
                    sub_word   = ~addr[0];
                    misaligned = addr[0];
                end
                default: misaligned = (addr[1:0] != 2'b00);
            endcase
        end
    end

    // Lane merge of the captured store into the previously read word.
    always_comb begin
        merged = old_q;
        if (op_q.size == SZ_BYTE) begin
            merged[{op_q.addr[1:0], 3'b000} +: 8] = op_q.wdata[7:0];
        end else begin
            merged[{op_q.addr[1], 4'b0000} +: 16] = op_q.wdata[15:0];
        end
    end

    // Next-state and memory-side outputs.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        old_d        = old_q;
        cnt_d        = cnt_q;
        dm_MemRead   = 1'b0;
        dm_MemWrite  = 1'b0;
        dm_a         = addr;
        dm_wd        = wdata;
        dm_Funct3    = Funct3;
        stall        = 1'b0;
        misalign_err = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_load) begin
                    dm_MemRead = 1'b1;
                end else if (sub_word) begin
                    dm_MemRead = 1'b1;
                    dm_a       = {addr[DM_ADDRESS-1:2], 2'b00};
                    dm_Funct3  = F3_WORD;
                    stall      = 1'b1;
                    old_d      = dm_rd;
                    op_d.addr  = addr;
                    op_d.wdata = wdata[15:0];
                    op_d.size  = Funct3[1:0];
                    state_d    = WRITE;
                end else if (misaligned) begin
                    misalign_err = 1'b1;
                end else if (is_store) begin
                    dm_MemWrite = 1'b1;
                end
            end
            WRITE: begin
                dm_MemWrite = 1'b1;
                dm_a        = {op_q.addr[DM_ADDRESS-1:2], 2'b00};
                dm_Funct3   = F3_WORD;
                dm_wd       = merged;
                state_d     = IDLE;
                cnt_d       = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Reset silences the memory port so an interrupted RMW never writes.
        if (!reset_n) begin
            dm_MemRead   = 1'b0;
            dm_MemWrite  = 1'b0;
            stall        = 1'b0;
            misalign_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            old_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            old_q   <= old_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rmw_count = cnt_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: a word-array memory model writing on the falling edge,
// a per-cycle vector table checked through an expectation queue, plus reset sequences.
module tb_mem_rmw_ctrl;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          MemRead, MemWrite;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0]    Funct3;
    logic          dm_MemRead, dm_MemWrite;
    logic [AW-1:0] dm_a;
    logic [DW-1:0] dm_wd;
    logic [2:0]    dm_Funct3;
    logic [DW-1:0] dm_rd;
    logic          stall, misalign_err;
    logic [CW-1:0] rmw_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_rmw_ctrl #(.DM_ADDRESS(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wdata(wdata), .Funct3(Funct3),
        .dm_MemRead(dm_MemRead), .dm_MemWrite(dm_MemWrite), .dm_a(dm_a), .dm_wd(dm_wd),
        .dm_Funct3(dm_Funct3), .dm_rd(dm_rd),
        .stall(stall), .misalign_err(misalign_err), .rmw_count(rmw_count)
    );

    // Data memory model: combinational read, full-word write on the falling edge.
    logic [DW-1:0] mem [0:127];
    assign dm_rd = mem[dm_a[AW-1:2]];
    always @(negedge clk) begin
        if (dm_MemWrite) mem[dm_a[AW-1:2]] <= dm_wd;
    end

    typedef struct {
        logic          mr, mw;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [2:0]    f3;
        logic          e_mr, e_mw;
        logic [AW-1:0] e_a;
        logic [DW-1:0] e_wd;
        logic [2:0]    e_f3;
        logic          e_stall, e_err;
        logic [CW-1:0] e_cnt;
        logic          chk_a, chk_wd;
    } vec_t;

    vec_t vecs[$];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic mr, input logic mw, input logic [AW-1:0] a,
                                input logic [DW-1:0] wd, input logic [2:0] f3,
                                input logic e_mr, input logic e_mw, input logic [AW-1:0] e_a,
                                input logic [DW-1:0] e_wd, input logic [2:0] e_f3,
                                input logic e_stall, input logic e_err, input logic [CW-1:0] e_cnt,
                                input logic chk_a, input logic chk_wd);
        vec_t v;
        v.mr = mr; v.mw = mw; v.a = a; v.wd = wd; v.f3 = f3;
        v.e_mr = e_mr; v.e_mw = e_mw; v.e_a = e_a; v.e_wd = e_wd; v.e_f3 = e_f3;
        v.e_stall = e_stall; v.e_err = e_err; v.e_cnt = e_cnt;
        v.chk_a = chk_a; v.chk_wd = chk_wd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic mw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [2:0] f3);
        MemRead = mr; MemWrite = mw; addr = a; wdata = wd; Funct3 = f3;
    endtask

    // One cycle: drive after the rising edge, compare before the falling edge.
    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v.mr, v.mw, v.a, v.wd, v.f3);
        sb_q.push_back(v);
        #3;
        e = sb_q.pop_front();
        chk($sformatf("v%0d.dm_MemRead", idx), DW'(dm_MemRead), DW'(e.e_mr));
        chk($sformatf("v%0d.dm_MemWrite", idx), DW'(dm_MemWrite), DW'(e.e_mw));
        chk($sformatf("v%0d.stall", idx), DW'(stall), DW'(e.e_stall));
        chk($sformatf("v%0d.misalign_err", idx), DW'(misalign_err), DW'(e.e_err));
        chk($sformatf("v%0d.rmw_count", idx), DW'(rmw_count), DW'(e.e_cnt));
        if (e.chk_a) begin
            chk($sformatf("v%0d.dm_a", idx), DW'(dm_a), DW'(e.e_a));
            chk($sformatf("v%0d.dm_Funct3", idx), DW'(dm_Funct3), DW'(e.e_f3));
        end
        if (e.chk_wd) chk($sformatf("v%0d.dm_wd", idx), dm_wd, e.e_wd);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = '0;
        mem[9'h010 >> 2] = 32'h0000_0000;
        mem[9'h020 >> 2] = 32'h1122_3344;
        mem[9'h030 >> 2] = 32'h5566_7788;
        mem[9'h034 >> 2] = 32'h99AA_BBCC;
        mem[9'h040 >> 2] = 32'hAAAA_BBBB;
        mem[9'h060 >> 2] = 32'hCAFE_F00D;

        // Reset with a sub-word store presented: nothing may leave the block.
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 9'h022, 32'hAB, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #4;
        chk("rst.stall", DW'(stall), 0);
        chk("rst.dm_MemRead", DW'(dm_MemRead), 0);
        chk("rst.dm_MemWrite", DW'(dm_MemWrite), 0);
        chk("rst.misalign_err", DW'(misalign_err), 0);
        chk("rst.rmw_count", DW'(rmw_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 9'h000, 32'h0, 3'b010);

        //            mr mw addr    wdata          f3      e_mr e_mw e_a     e_wd           e_f3    st er cnt chkA chkWD
        vecs.push_back(mk(0, 0, 9'h000, 32'h0,        3'b010, 0, 0, 9'h000, 32'h0,        3'b010, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 1, 9'h010, 32'hDEADBEEF, 3'b010, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 9'h022, 32'h000000AB, 3'b000, 1, 0, 9'h020, 32'h0,        3'b010, 1, 0, 0, 1, 0));
        vecs.push_back(mk(0, 1, 9'h022, 32'h000000AB, 3'b000, 0, 1, 9'h020, 32'h11AB3344, 3'b010, 0, 0, 0, 1, 1));
        vecs.push_back(mk(0, 1, 9'h042, 32'h00001234, 3'b001, 1, 0, 9'h040, 32'h0,        3'b010, 1, 0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 9'h042, 32'h00001234, 3'b001, 0, 1, 9'h040, 32'h1234BBBB, 3'b010, 0, 0, 1, 1, 1));
        vecs.push_back(mk(1, 0, 9'h040, 32'h0,        3'b010, 1, 0, 9'h040, 32'h0,        3'b010, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 9'h031, 32'h0000FFFF, 3'b001, 0, 0, 9'h000, 32'h0,        3'b000, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 1, 9'h036, 32'hFFFFFFFF, 3'b010, 0, 0, 9'h000, 32'h0,        3'b000, 0, 1, 2, 0, 0));
        vecs.push_back(mk(0, 0, 9'h036, 32'h0,        3'b010, 0, 0, 9'h000, 32'h0,        3'b000, 0, 0, 2, 0, 0));
        vecs.push_back(mk(1, 1, 9'h050, 32'h12345678, 3'b010, 1, 0, 9'h050, 32'h0,        3'b010, 0, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 9'h050, 32'h00000011, 3'b000, 1, 0, 9'h050, 32'h0,        3'b010, 1, 0, 2, 1, 0));
        vecs.push_back(mk(0, 1, 9'h050, 32'h00000011, 3'b000, 0, 1, 9'h050, 32'h00000011, 3'b010, 0, 0, 2, 1, 1));
        vecs.push_back(mk(0, 1, 9'h053, 32'h00000022, 3'b000, 1, 0, 9'h050, 32'h0,        3'b010, 1, 0, 3, 1, 0));
        vecs.push_back(mk(0, 1, 9'h053, 32'h00000022, 3'b000, 0, 1, 9'h050, 32'h22000011, 3'b010, 0, 0, 3, 1, 1));
        vecs.push_back(mk(1, 0, 9'h051, 32'h0,        3'b100, 1, 0, 9'h051, 32'h0,        3'b100, 0, 0, 4, 1, 0));

        foreach (vecs[i]) apply(i, vecs[i]);

        #2;
        chk("mem.sw", mem[9'h010 >> 2], 32'hDEADBEEF);
        chk("mem.sb", mem[9'h020 >> 2], 32'h11AB3344);
        chk("mem.sh_lw", mem[9'h040 >> 2], 32'h1234BBBB);
        chk("mem.misalign_sh", mem[9'h030 >> 2], 32'h55667788);
        chk("mem.misalign_sw", mem[9'h034 >> 2], 32'h99AABBCC);
        chk("mem.b2b_sb", mem[9'h050 >> 2], 32'h22000011);

        // Reset asserted during the WRITE cycle of an SB abandons the RMW.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 9'h061, 32'h00000077, 3'b000);
        #3;
        chk("rmw_rst.read_stall", DW'(stall), 1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #3;
        chk("rmw_rst.dm_MemWrite", DW'(dm_MemWrite), 0);
        chk("rmw_rst.stall", DW'(stall), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 9'h000, 32'h0, 3'b010);
        #3;
        chk("rmw_rst.mem", mem[9'h060 >> 2], 32'hCAFEF00D);
        chk("rmw_rst.rmw_count", DW'(rmw_count), 0);
        chk("rmw_rst.stall_after", DW'(stall), 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b1, 9'h060, 32'h01020304, 3'b010);
        #3;
        chk("rmw_rst.idle_sw", DW'(dm_MemWrite), 1);
        chk("rmw_rst.idle_sw_stall", DW'(stall), 0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 9'h000, 32'h0, 3'b010);
        #3;
        chk("rmw_rst.sw_mem", mem[9'h060 >> 2], 32'h01020304);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
